serializer_tx_ctrl: RTL and testbench

//  Sequencer for the team's 8-bit MSB-first shift serializer (write has priority over enable).
//  - Accepts bytes on a valid/ready handshake.
//  - Drives the serializer's write, data and enable inputs so each bit is held DIV clocks.
//  - Frames the 8 bits with out_frame, then inserts an optional idle gap.
//  - Sits between the byte producer and the serializer on the transmit path.

---
 rtl/serializer_pkg.sv | 17 +
 rtl/serializer_tx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_serializer_tx_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
// Shared definitions for the transmit-side serializer path.
//   SER_WIDTH : number of bits the shift serializer holds and shifts out
//   state_t   : sequencer state encoding (IDLE, SEND, GAP)
// ---------------------------------------------------------------------------
package serializer_pkg;

  localparam int SER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/serializer_tx_ctrl.sv
// ---------------------------------------------------------------------------
// serializer_tx_ctrl
// Sequencer between a byte producer and the 8-bit MSB-first shift serializer.
// Accepts a byte on a valid/ready handshake, loads it into the serializer on
// the accept edge, then strobes the serializer's shift enable so that every
// bit is held for DIV clocks. out_frame marks the cycles on which the
// serializer output carries a data bit; an optional idle gap of GAP_CYCLES
// clocks follows each byte.
//
// Ports
//   in_clock        single clock, all logic on posedge
//   in_reset        asynchronous active-high reset
//   in_valid        producer has a byte on in_data
//   in_data         byte to transmit
//   in_abort        synchronous abort of the byte in flight
//   out_ready       controller accepts in_data this cycle
//   out_ser_write   serializer load strobe (same cycle as the accept)
//   out_ser_data    serializer load data (passthrough of in_data)
//   out_ser_enable  serializer shift strobe
//   out_frame       serializer output carries a valid data bit
//   out_busy        high in SEND or GAP
//   out_done        one-cycle pulse on the final clock of bit 7
// ---------------------------------------------------------------------------
module serializer_tx_ctrl
  import serializer_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_valid,
  input  logic [SER_WIDTH-1:0] in_data,
  input  logic                 in_abort,
  output logic                 out_ready,
  output logic                 out_ser_write,
  output logic [SER_WIDTH-1:0] out_ser_data,
  output logic                 out_ser_enable,
  output logic                 out_frame,
  output logic                 out_busy,
  output logic                 out_done
);

  localparam int DIV_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_INT);
  localparam logic [2:0]       BIT_LAST = 3'(SER_WIDTH - 1);

  state_t             state_q,   state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               frame_q,   frame_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic last_div;
  logic last_bit;
  logic last_clk;
  logic accept;

  assign last_div = (div_cnt_q == DIV_LAST);
  assign last_bit = (bit_cnt_q == BIT_LAST);
  assign last_clk = (state_q == SEND) && last_div && last_bit;

  // Ready in IDLE, and with no gap configured also on the last SEND clock so
  // that a held in_valid streams bytes without a break in out_frame. An abort
  // on that last clock withdraws the back-to-back offer.
  assign out_ready = !in_reset &&
                     ((state_q == IDLE) ||
                      ((GAP_CYCLES == 0) && last_clk && !in_abort));
  assign accept    = in_valid && out_ready;

  // State register: FSM state, counters and the registered status outputs.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. Abort wins over everything outside IDLE; on the last
  // clock of bit 7 an accept restarts the frame, otherwise we go to GAP or
  // straight back to IDLE.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SEND;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end

      SEND: begin
        if (in_abort) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (last_div) begin
          div_cnt_d = '0;
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            bit_cnt_d = '0;
            if (accept) begin
              state_d = SEND;
            end else if (GAP_CYCLES > 0) begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (in_abort || (gap_cnt_q == GAP_LAST)) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        gap_cnt_d = '0;
      end
    endcase
  end

  // Output logic. The serializer loads on the accept edge, so write and data
  // are pure passthroughs. The status flops are fed from the next state so
  // that they line up with the cycles they describe; out_done is set when
  // the next cycle is the final clock of bit 7.
  always_comb begin
    out_ser_write  = accept;
    out_ser_data   = in_data;
    out_ser_enable = (state_q == SEND) && last_div && !last_bit;

    frame_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == SEND) && (bit_cnt_d == BIT_LAST) &&
              (div_cnt_d == DIV_LAST);
  end

  assign out_frame = frame_q;
  assign out_busy  = busy_q;
  assign out_done  = done_q;

endmodule

// File: tb/tb_serializer_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serializer_tx_ctrl
// Three controller instances (DIV=4/GAP=0, DIV=4/GAP=3, DIV=1/GAP=0), each
// feeding a behavioural 8-bit MSB-first shift serializer (write beats enable).
// A frame-level reference model predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_serializer_tx_ctrl;

  localparam int NUM = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid   [NUM];
  logic       abort   [NUM];
  logic [7:0] data    [NUM];
  logic       rdy     [NUM];
  logic       wr      [NUM];
  logic [7:0] sdata   [NUM];
  logic       en      [NUM];
  logic       frame   [NUM];
  logic       busy    [NUM];
  logic       done    [NUM];
  logic [7:0] sreg    [NUM];

  // Reference model: position within the current frame (-1 when not
  // sending), idle gap clocks still to come, and the byte being sent.
  int         m_t     [NUM];
  int         m_gap   [NUM];
  logic [7:0] m_cur   [NUM];

  int checks   = 0;
  int failures = 0;

  function automatic int div_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  serializer_tx_ctrl #(.DIV(4), .GAP_CYCLES(0)) u_dut0 (
    .in_clock(clock), .in_reset(reset), .in_valid(valid[0]), .in_data(data[0]),
    .in_abort(abort[0]), .out_ready(rdy[0]), .out_ser_write(wr[0]),
    .out_ser_data(sdata[0]), .out_ser_enable(en[0]), .out_frame(frame[0]),
    .out_busy(busy[0]), .out_done(done[0])
  );

  serializer_tx_ctrl #(.DIV(4), .GAP_CYCLES(3)) u_dut1 (
    .in_clock(clock), .in_reset(reset), .in_valid(valid[1]), .in_data(data[1]),
    .in_abort(abort[1]), .out_ready(rdy[1]), .out_ser_write(wr[1]),
    .out_ser_data(sdata[1]), .out_ser_enable(en[1]), .out_frame(frame[1]),
    .out_busy(busy[1]), .out_done(done[1])
  );

  serializer_tx_ctrl #(.DIV(1), .GAP_CYCLES(0)) u_dut2 (
    .in_clock(clock), .in_reset(reset), .in_valid(valid[2]), .in_data(data[2]),
    .in_abort(abort[2]), .out_ready(rdy[2]), .out_ser_write(wr[2]),
    .out_ser_data(sdata[2]), .out_ser_enable(en[2]), .out_frame(frame[2]),
    .out_busy(busy[2]), .out_done(done[2])
  );

  // The downstream shift serializers: load has priority over shift.
  always @(posedge clock) begin
    for (int k = 0; k < NUM; k++) begin
      if (wr[k])
        sreg[k] <= sdata[k];
      else if (en[k])
        sreg[k] <= {sreg[k][6:0], 1'b0};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One model cycle for instance k: compare everything visible now, then
  // advance the model across the coming clock edge.
  task automatic model_step(input int k);
    int   d, g, last;
    logic active, aborting, exp_rdy, exp_wr;
    d    = div_of(k);
    g    = gap_of(k);
    last = 8 * d - 1;
    if (reset) begin
      m_t[k]   = -1;
      m_gap[k] = 0;
    end
    active   = (m_t[k] >= 0) || (m_gap[k] > 0);
    aborting = abort[k] && active && !reset;
    exp_rdy  = !reset && (!active || (g == 0 && m_t[k] == last && !abort[k]));
    exp_wr   = valid[k] && exp_rdy;

    checkOutput($sformatf("i%0d.ready", k), 32'(rdy[k]), 32'(exp_rdy));
    checkOutput($sformatf("i%0d.write", k), 32'(wr[k]), 32'(exp_wr));
    checkOutput($sformatf("i%0d.frame", k), 32'(frame[k]), 32'(m_t[k] >= 0));
    checkOutput($sformatf("i%0d.busy", k), 32'(busy[k]), 32'(active));
    checkOutput($sformatf("i%0d.done", k), 32'(done[k]), 32'(m_t[k] == last));
    if (!aborting)
      checkOutput($sformatf("i%0d.enable", k), 32'(en[k]),
                  32'((m_t[k] >= 0) && (m_t[k] % d == d - 1) && (m_t[k] / d < 7)));
    if (m_t[k] >= 0)
      checkOutput($sformatf("i%0d.bit t=%0d", k, m_t[k]), 32'(sreg[k][7]),
                  32'(m_cur[k][7 - m_t[k] / d]));
    if (exp_wr)
      checkOutput($sformatf("i%0d.ser_data", k), 32'(sdata[k]), 32'(data[k]));

    if (reset) begin
    end else if (aborting) begin
      m_t[k]   = -1;
      m_gap[k] = 0;
    end else if (exp_wr) begin
      m_t[k]   = 0;
      m_cur[k] = data[k];
    end else if (m_t[k] >= 0) begin
      if (m_t[k] == last) begin
        m_t[k]   = -1;
        m_gap[k] = g;
      end else begin
        m_t[k]++;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end
  endtask

  // Model comparisons on the falling edge, away from the active edge.
  always @(negedge clock) begin
    for (int k = 0; k < NUM; k++) model_step(k);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Holds the current in_valid/in_data until the controller accepts them;
  // returns just after the accepting edge.
  task automatic wait_accept(input int k);
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      if (rdy[k] && valid[k]) got = 1;
      @(posedge clock);
      #1;
    end
    checkOutput($sformatf("i%0d.accept_in_time", k), 32'(got), 32'd1);
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] b);
    valid[k] = 1'b1;
    data[k]  = b;
    wait_accept(k);
    valid[k] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      valid[k] = 1'b0;
      abort[k] = 1'b0;
      data[k]  = 8'h00;
      m_t[k]   = -1;
      m_gap[k] = 0;
      m_cur[k] = 8'h00;
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    wait_cycles(2);

    $display("[TB] single byte 0xA5, DIV=4");
    applyStimulus(0, 8'hA5);
    wait_cycles(40);

    $display("[TB] back-to-back 0x3C, 0xC3 with valid held");
    valid[0] = 1'b1;
    data[0]  = 8'h3C;
    wait_accept(0);
    data[0]  = 8'hC3;
    wait_accept(0);
    valid[0] = 1'b0;
    wait_cycles(40);

    $display("[TB] two bytes with a 3-clock gap");
    valid[1] = 1'b1;
    data[1]  = 8'h12;
    wait_accept(1);
    data[1]  = 8'h34;
    wait_accept(1);
    valid[1] = 1'b0;
    wait_cycles(45);

    $display("[TB] in_valid pulse mid-frame is ignored");
    applyStimulus(0, 8'h5A);
    wait_cycles(9);
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    wait_cycles(1);
    valid[0] = 1'b0;
    wait_cycles(30);

    $display("[TB] abort at bit 3 of 0x81, then 0x01");
    applyStimulus(0, 8'h81);
    wait_cycles(12);
    abort[0] = 1'b1;
    wait_cycles(1);
    abort[0] = 1'b0;
    checkOutput("abort.ready_after", 32'(rdy[0]), 32'd1);
    checkOutput("abort.frame_after", 32'(frame[0]), 32'd0);
    applyStimulus(0, 8'h01);
    wait_cycles(40);

    $display("[TB] DIV=1 byte 0x96, then async reset mid-frame");
    applyStimulus(2, 8'h96);
    wait_cycles(12);
    applyStimulus(2, 8'h69);
    wait_cycles(3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst.frame_now", 32'(frame[2]), 32'd0);
    checkOutput("rst.busy_now", 32'(busy[2]), 32'd0);
    checkOutput("rst.done_now", 32'(done[2]), 32'd0);
    checkOutput("rst.ready_now", 32'(rdy[2]), 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
    checkOutput("rst.ready_after", 32'(rdy[2]), 32'd1);
    checkOutput("rst.busy_after", 32'(busy[2]), 32'd0);
    applyStimulus(2, 8'hC7);
    wait_cycles(12);

    $display("[TB] randomized traffic on each instance");
    for (int k = 0; k < NUM; k++) begin
      repeat (400) begin
        valid[k] = ($urandom_range(0, 2) != 0);
        data[k]  = 8'($urandom);
        abort[k] = ($urandom_range(0, 24) == 0);
        wait_cycles(1);
      end
      valid[k] = 1'b0;
      abort[k] = 1'b0;
      wait_cycles(45);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
